sr_ff_sequencer: RTL and testbench

Command-driven controller for a single SR flip-flop (ports q, qbar, clk, reset, sr[1:0]). It accepts set/clear/toggle/pulse commands over a valid/ready handshake and converts them into timed sr drive sequences. It never drives the forbidden 2'b11 code, inserts hold cycles between drives, and can check the flip-flop's q/qbar feedback after each command. It sits between the command source and the flip-flop; the flip-flop's own reset input stays under system control.

---
 rtl/sr_ff_sequencer.sv | 144 ++++++++++++++
 tb/tb_sr_ff_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sr_ff_sequencer.sv
// rtl/sr_ff_sequencer.sv - command-driven set/clear/toggle/pulse sequencer for one SR flip-flop
// Define SR_FB_CHECK_EN to flag q/qbar feedback mismatches in CHECK; otherwise only illegal ops raise err.
module sr_ff_sequencer #(
  parameter int PULSE_W    = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [2:0]         cmd_op_i,
  input  logic [PULSE_W-1:0] cmd_len_i,
  output logic [1:0]         sr_o,
  input  logic               q_fb_i,
  input  logic               qbar_fb_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               err_sticky_o
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_CLR   = 3'd2;
  localparam logic [2:0] OP_TOG   = 3'd3;
  localparam logic [2:0] OP_PULSE = 3'd4;
  localparam logic [1:0] SR_SET   = 2'b10;
  localparam logic [1:0] SR_CLR   = 2'b01;
  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t             state_q;
  logic [PULSE_W-1:0] cnt_q;
  logic [3:0]         scnt_q;
  logic [1:0]         sr_q;
  logic               exp_q, phase2_q, ready_q, busy_q, done_q, err_q, sticky_q;

  logic               new_exp, fb_bad;
  logic [PULSE_W-1:0] len_m1;

  // TOGGLE picks its direction from q_fb at the accept edge
  assign new_exp = (cmd_op_i == OP_SET) || ((cmd_op_i == OP_TOG) && !q_fb_i);
  assign len_m1  = (cmd_len_i == '0) ? '0 : cmd_len_i - PULSE_W'(1);

`ifdef SR_FB_CHECK_EN
  assign fb_bad = (q_fb_i != exp_q) || (qbar_fb_i == q_fb_i);
`else
  logic unused_fb;
  assign unused_fb = ^{qbar_fb_i, exp_q};
  assign fb_bad    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      scnt_q   <= '0;
      sr_q     <= SR_HOLD;
      exp_q    <= 1'b0;
      phase2_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      sr_q   <= SR_HOLD;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            case (cmd_op_i)
              OP_SET, OP_CLR, OP_TOG: begin
                state_q  <= DRIVE;
                exp_q    <= new_exp;
                sr_q     <= new_exp ? SR_SET : SR_CLR;
                cnt_q    <= '0;
                phase2_q <= 1'b0;
              end
              OP_PULSE: begin
                state_q  <= DRIVE;
                exp_q    <= 1'b0;
                sr_q     <= SR_SET;
                cnt_q    <= len_m1;
                phase2_q <= 1'b1;
              end
              default: begin
                state_q <= CHECK;
                done_q  <= 1'b1;
                if (cmd_op_i != OP_NOP) begin
                  err_q    <= 1'b1;
                  sticky_q <= 1'b1;
                end
              end
            endcase
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_q <= SETTLE;
            scnt_q  <= SETTLE_LAST;
          end else begin
            cnt_q <= cnt_q - PULSE_W'(1);
            sr_q  <= sr_q;
          end
        end
        SETTLE: begin
          if (scnt_q != 4'd0) begin
            scnt_q <= scnt_q - 4'd1;
          end else if (phase2_q) begin
            state_q  <= DRIVE;
            sr_q     <= SR_CLR;
            cnt_q    <= '0;
            phase2_q <= 1'b0;
          end else begin
            state_q <= CHECK;
            done_q  <= 1'b1;
            err_q   <= fb_bad;
            if (fb_bad) sticky_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // ready_q is already high in reset; gating keeps cmd_ready low only while reset is held
  assign cmd_ready_o  = ready_q && !reset_i;
  assign sr_o         = sr_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_sr_ff_sequencer.sv
// tb/tb_sr_ff_sequencer.sv - directed self-checking bench for sr_ff_sequencer with an SR flip-flop model
module tb_sr_ff_sequencer;
  localparam int PW   = 8;
  localparam int S    = 2;
  localparam int MAXT = 600;
`ifdef SR_FB_CHECK_EN
  localparam logic FB_ERR = 1'b1;
`else
  localparam logic FB_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [PW-1:0] cmd_len = '0;
  logic [1:0]    sr;
  logic          q_fb, qbar_fb, busy, done, err, err_sticky;

  logic ff_q = 1'b0;
  logic stuck0 = 1'b0;
  logic saw_11 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] tr_sr   [0:MAXT-1];
  logic       tr_done [0:MAXT-1];
  logic       tr_err  [0:MAXT-1];
  logic       tr_busy [0:MAXT-1];

  always #5 clk = ~clk;

  sr_ff_sequencer #(.PULSE_W(PW), .SETTLE_CYC(S)) dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .sr_o(sr), .q_fb_i(q_fb), .qbar_fb_i(qbar_fb),
    .busy_o(busy), .done_o(done), .err_o(err), .err_sticky_o(err_sticky)
  );

  // flip-flop model, optionally stuck at 0
  always @(posedge clk) begin
    if (stuck0)              ff_q <= 1'b0;
    else if (sr == 2'b10)    ff_q <= 1'b1;
    else if (sr == 2'b01)    ff_q <= 1'b0;
  end
  assign q_fb    = ff_q;
  assign qbar_fb = ~ff_q;

  always @(negedge clk) if (sr == 2'b11) saw_11 <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; traces until cmd_ready returns, then checks the trace.
  task automatic run(input string tag, input logic [2:0] op, input logic [PW-1:0] len,
                     input logic [1:0] code, input logic exp_err);
    int n, b, l, lim;
    logic [1:0] es;
    check({tag, " ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd7; cmd_len = '1;
    n = 0;
    while (n < MAXT) begin
      tr_sr[n] = sr; tr_done[n] = done; tr_err[n] = err; tr_busy[n] = busy;
      if (cmd_ready) break;
      n++;
      @(negedge clk);
    end
    check({tag, " ready_returns"}, n < MAXT, 1);
    l = (len == '0) ? 1 : int'(len);
    if (op == 3'd4)                    b = l + 2*S + 2;
    else if (op >= 3'd1 && op <= 3'd3) b = S + 2;
    else                               b = 1;
    check({tag, " busy_cycles"}, n, b);
    lim = (n < b) ? n : b;
    for (int i = 0; i < lim; i++) begin
      if (op == 3'd4)                    es = (i < l) ? 2'b10 : ((i == l + S) ? 2'b01 : 2'b00);
      else if (op >= 3'd1 && op <= 3'd3) es = (i == 0) ? code : 2'b00;
      else                               es = 2'b00;
      check($sformatf("%s sr[%0d]", tag, i), tr_sr[i], es);
      check($sformatf("%s busy[%0d]", tag, i), tr_busy[i], 1);
      check($sformatf("%s done[%0d]", tag, i), tr_done[i], i == b - 1);
      check($sformatf("%s err[%0d]", tag, i), tr_err[i], (i == b - 1) && exp_err);
    end
    if (n < MAXT) begin
      check({tag, " idle_busy"}, tr_busy[n], 0);
      check({tag, " idle_done"}, tr_done[n], 0);
      check({tag, " idle_sr"}, tr_sr[n], 2'b00);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst sr", sr, 2'b00);
    check("rst ready", cmd_ready, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst sticky", err_sticky, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    run("set", 3'd1, 8'd0, 2'b10, 1'b0);    check("set q", ff_q, 1);
    run("tog1", 3'd3, 8'd0, 2'b01, 1'b0);   check("tog1 q", ff_q, 0);
    run("tog0", 3'd3, 8'd0, 2'b10, 1'b0);   check("tog0 q", ff_q, 1);
    run("clr", 3'd2, 8'd9, 2'b01, 1'b0);    check("clr q", ff_q, 0);
    run("pulse3", 3'd4, 8'd3, 2'b00, 1'b0); check("pulse3 q", ff_q, 0);
    run("pulse0", 3'd4, 8'd0, 2'b00, 1'b0);
    run("pulse255", 3'd4, 8'hFF, 2'b00, 1'b0);
    run("nop", 3'd0, 8'd5, 2'b00, 1'b0);    check("nop sticky", err_sticky, 0);

    stuck0 = 1'b1;
    run("stuck_set", 3'd1, 8'd0, 2'b10, FB_ERR);
    check("stuck sticky", err_sticky, FB_ERR);
    run("stuck_clr", 3'd2, 8'd0, 2'b01, 1'b0);
    check("stuck sticky hold", err_sticky, FB_ERR);
    stuck0 = 1'b0;

    run("ill6", 3'd6, 8'd0, 2'b00, 1'b1);
    check("ill6 sticky", err_sticky, 1);

    // reset during the PULSE high phase
    check("rstmid ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_len = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rstmid driving", sr, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid sr", sr, 2'b00);
    check("rstmid done", done, 0);
    check("rstmid err", err, 0);
    check("rstmid busy", busy, 0);
    check("rstmid ready_low", cmd_ready, 0);
    @(negedge clk);
    check("rstmid sticky", err_sticky, 0);
    check("rstmid done2", done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid ready", cmd_ready, 1);
    check("rstmid idle_sr", sr, 2'b00);
    check("rstmid idle_done", done, 0);
    run("after_rst_clr", 3'd2, 8'd0, 2'b01, 1'b0);
    check("after_rst q", ff_q, 0);

    check("never_sr11", saw_11, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
